// File: rtl/lane_sum_pkg.sv
// Shared types for the lane-sum engine: command opcodes and FSM states.
// Optional build macro LANE_SUM_SAT_EN clamps sums to the lane width.
package lane_sum_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_SINGLE = 2'd1,
        OP_SWEEP  = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/lane_sum_adder.sv
// Combinational lane0 + lane k; k of 0 or out of range yields 0.
// With LANE_SUM_SAT_EN defined the sum clamps to 2^LANE_W-1.
module lane_sum_adder
    import lane_sum_pkg::*;
#(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    parameter int SEL_W  = $clog2(LANES)
) (
    input  logic [LANE_W*LANES-1:0] data,
    input  logic [SEL_W-1:0]        k,
    output logic [LANE_W:0]         sum
);

    logic [LANE_W-1:0] lane_k;
    logic              k_ok;
    logic [LANE_W:0]   raw;

    always_comb begin
        lane_k = '0;
        k_ok   = 1'b0;
        for (int i = 1; i < LANES; i++) begin
            if (k == SEL_W'(i)) begin
                lane_k = data[i*LANE_W +: LANE_W];
                k_ok   = 1'b1;
            end
        end
        raw = {1'b0, data[LANE_W-1:0]} + {1'b0, lane_k};
`ifdef LANE_SUM_SAT_EN
        if (raw[LANE_W]) begin
            raw = {1'b0, {LANE_W{1'b1}}};
        end
`endif
        sum = k_ok ? raw : '0;
    end

endmodule

// File: rtl/lane_sum_engine.sv
// Lane-sum engine: LOAD/SINGLE/SWEEP commands, registered valid/ready output.
// Build macro LANE_SUM_SAT_EN selects saturating sums (see lane_sum_adder).
module lane_sum_engine
    import lane_sum_pkg::*;
#(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    parameter int SEL_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [SEL_W-1:0]        cmd_sel,
    input  logic [LANE_W*LANES-1:0] d,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANE_W:0]         out,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    out_last,
    output logic                    busy
);

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        k_q, k_d;
    logic [LANE_W*LANES-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic [LANE_W:0]         sum_q, sum_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic                    last_q, last_d;

    op_e              op;
    logic             accept;
    logic             xfer;
    logic [SEL_W-1:0] add_k;
    logic [LANE_W:0]  add_sum;
    logic             k_last;

    assign op     = op_e'(cmd_op);
    assign xfer   = valid_q && out_ready;
    assign k_last = (k_q == SEL_W'(LANES-1));
    assign add_k  = (state_q == ST_SWEEP) ? k_q : cmd_sel;

    // Gated by rst so every output reads 0 while reset is held.
    assign cmd_ready = rst && (state_q == ST_IDLE) && !valid_q;
    assign accept    = cmd_valid && cmd_ready;

    lane_sum_adder #(
        .LANE_W (LANE_W),
        .LANES  (LANES),
        .SEL_W  (SEL_W)
    ) u_adder (
        .data (data_q),
        .k    (add_k),
        .sum  (add_sum)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        data_d  = data_q;
        valid_d = valid_q && !xfer;
        sum_d   = sum_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD: data_d = d;
                        OP_SINGLE: begin
                            valid_d = 1'b1;
                            sum_d   = add_sum;
                            idx_d   = cmd_sel;
                            last_d  = 1'b1;
                        end
                        OP_SWEEP: begin
                            state_d = ST_SWEEP;
                            k_d     = SEL_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
            ST_SWEEP: begin
                if (!valid_q || xfer) begin
                    valid_d = 1'b1;
                    sum_d   = add_sum;
                    idx_d   = k_q;
                    last_d  = k_last;
                    if (k_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        k_d = k_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out       = sum_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign busy      = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_lane_sum_engine.sv
// Scoreboard bench for lane_sum_engine: directed timing cases plus random traffic.
module tb_lane_sum_engine;

    localparam int LANE_W = 4;
    localparam int LANES  = 4;
    localparam int SEL_W  = $clog2(LANES);
    localparam int DW     = LANE_W * LANES;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [SEL_W-1:0]  cmd_sel = '0;
    logic [DW-1:0]     d = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [LANE_W:0]   out;
    logic [SEL_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;

    lane_sum_engine #(.LANE_W(LANE_W), .LANES(LANES)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .d(d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_idx(out_idx), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int idx;
        int last;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    int   model_lanes[LANES];
    logic ready_force = 1'b1;
    logic ready_val   = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: zero-extended lane0 + lane k, 0 for k==0 or k out of range.
    function automatic int ref_sum(input int k);
        int s;
        if (k == 0 || k >= LANES) return 0;
        s = model_lanes[0] + model_lanes[k];
`ifdef LANE_SUM_SAT_EN
        if (s > (1 << LANE_W) - 1) s = (1 << LANE_W) - 1;
`endif
        return s;
    endfunction

    always @(posedge clk) begin
        #2;
        out_ready = ready_force ? ready_val : 1'($urandom_range(0, 1));
    end

    // Monitor: pops one expectation per transfer, checks hold while stalled.
    logic hold_pending = 1'b0;
    int   held_sum, held_idx, held_last;
    always @(negedge clk) begin
        if (!rst || !out_valid) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_out", int'(out), held_sum);
                check("hold_idx", int'(out_idx), held_idx);
                check("hold_last", int'(out_last), held_last);
            end
            if (out_ready) begin
                hold_pending = 1'b0;
                if (sbq.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("out", int'(out), e.sum);
                    check("out_idx", int'(out_idx), e.idx);
                    check("out_last", int'(out_last), e.last);
                end
            end else begin
                hold_pending = 1'b1;
                held_sum  = int'(out);
                held_idx  = int'(out_idx);
                held_last = int'(out_last);
            end
        end
    end

    task automatic issue(input int op, input int sel, input logic [DW-1:0] data);
        int n = 0;
        cmd_op    = 2'(op);
        cmd_sel   = SEL_W'(sel);
        d         = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        case (op)
            0: for (int i = 0; i < LANES; i++)
                   model_lanes[i] = int'(data[i*LANE_W +: LANE_W]);
            1: sbq.push_back('{ref_sum(sel), sel, 1});
            2: for (int k = 1; k < LANES; k++)
                   sbq.push_back('{ref_sum(k), k, (k == LANES - 1) ? 1 : 0});
            default: ;
        endcase
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < LANES; i++) model_lanes[i] = 0;
        #12;
        check("reset_cmd_ready", int'(cmd_ready), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_reset_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;

        issue(0, 0, 16'hF3A5);
        check("load_keeps_ready", int'(cmd_ready), 1);
        check("load_no_result", int'(out_valid), 0);
        issue(1, 1, '0);
        check("single_latency", int'(out_valid), 1);
        check("single_ready_low", int'(cmd_ready), 0);
        issue(1, 3, '0);

        issue(2, 0, '0);
        check("sweep_busy", int'(busy), 1);
        check("sweep_first_not_yet", int'(out_valid), 0);
        for (int j = 1; j < LANES; j++) begin
            @(posedge clk);
            #1;
            check("sweep_b2b_valid", int'(out_valid), 1);
            check("sweep_b2b_idx", int'(out_idx), j);
        end
        @(posedge clk);
        #1;
        check("sweep_end_ready", int'(cmd_ready), 1);
        check("sweep_end_busy", int'(busy), 0);

        issue(2, 0, '0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 ready_val = 1'b0;
        check("stall_idx", int'(out_idx), 2);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_hold_idx", int'(out_idx), 2);
            check("stall_hold_out", int'(out), ref_sum(2));
        end
        ready_val = 1'b1;

        issue(1, 0, '0);
        issue(3, 0, 16'h1234);
        @(posedge clk);
        #1;
        check("rsvd_no_output", int'(out_valid), 0);
        issue(1, 2, '0);

        issue(2, 0, '0);
        @(posedge clk);
        #1;
        check("rst_sweep_idx1", int'(out_idx), 1);
        #2 rst = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'(out), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        sbq.delete();
        for (int i = 0; i < LANES; i++) model_lanes[i] = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rel_busy", int'(busy), 0);
        check("rel_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        issue(1, 2, '0);

        ready_force = 1'b0;
        for (int n = 0; n < 60; n++) begin
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, LANES - 1)),
                  DW'($urandom));
        end

        ready_force = 1'b1;
        ready_val   = 1'b1;
        for (int n = 0; n < 100 && (sbq.size() != 0 || busy || out_valid); n++)
            @(posedge clk);
        @(negedge clk);
        check("drain_queue_empty", sbq.size(), 0);
        check("drain_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
